// File: rtl/dtlb_stage_pkg.sv
// Shared definitions for the data-side TLB stage: EntryHi/EntryLo field
// offsets, default geometry, segment decode constants and entry layout.
package dtlb_stage_pkg;

  localparam int TLB_ENTRIES_DEF = 16;
  localparam int IDX_W_DEF       = 4;

  // Pipeline stall vector; this stage honours one bit of it.
  localparam int STALL_W   = 6;
  localparam int STALL_BIT = 4;

  // EntryHi fields
  localparam int EH_VPN2_HI = 31;
  localparam int EH_VPN2_LO = 13;
  localparam int EH_ASID_HI = 7;
  localparam int EH_ASID_LO = 0;

  // EntryLo fields
  localparam int EL_PFN_HI = 25;
  localparam int EL_PFN_LO = 6;
  localparam int EL_C_HI   = 5;
  localparam int EL_C_LO   = 3;
  localparam int EL_D      = 2;
  localparam int EL_V      = 1;
  localparam int EL_G      = 0;

  // Segment decode on vaddr[31:29]
  localparam logic [2:0]  SEG_KSEG0    = 3'b100;
  localparam logic [2:0]  SEG_KSEG1    = 3'b101;
  localparam logic [31:0] KSEG_MASK    = 32'h1FFF_FFFF;
  localparam logic [2:0]  C_CACHEABLE  = 3'd3;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_page_t   lo0;
    tlb_page_t   lo1;
  } tlb_entry_t;

  // Rebuild the architectural EntryLo word for TLBR.
  function automatic logic [31:0] pack_lo(input tlb_page_t p, input logic g);
    return {6'b0, p.pfn, p.c, p.d, p.v, g};
  endfunction

endpackage

// File: rtl/dtlb_stage_if.sv
// Load/store translation bus between the execute stage (master) and the
// data TLB stage (slave). Results are combinational on the same cycle.
interface dtlb_stage_if;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] vaddr;
  logic [7:0]  cur_asid;
  logic [31:0] paddr;
  logic        uncached;
  logic        d_refill;
  logic        d_invalid;
  logic        d_modify;

  modport master (
    output mem_en, mem_we, vaddr, cur_asid,
    input  paddr, uncached, d_refill, d_invalid, d_modify
  );

  modport slave (
    input  mem_en, mem_we, vaddr, cur_asid,
    output paddr, uncached, d_refill, d_invalid, d_modify
  );

endinterface

// File: rtl/dtlb_stage_match.sv
// Single-entry comparator: VPN2/ASID/G match and even/odd page select.
module dtlb_match
  import dtlb_stage_pkg::*;
(
  input  tlb_entry_t  entry,
  input  logic [18:0] vpn2,
  input  logic        odd,
  input  logic [7:0]  asid,
  output logic        hit,
  output tlb_page_t   page
);

  // Global entries ignore the ASID entirely.
  assign hit  = (entry.vpn2 == vpn2) && (entry.g || (entry.asid == asid));
  assign page = odd ? entry.lo1 : entry.lo0;

endmodule

// File: rtl/dtlb_stage.sv
// Data-side translation stage: fully-associative joint TLB (4 KB pages),
// combinational lookup, CP0 TLBWI/TLBWR/TLBP/TLBR support and Random.
// Optional macro DTLB_PERF_EN adds a saturating refill-miss counter.
module dtlb_stage
  import dtlb_stage_pkg::*;
#(
  parameter int TLB_ENTRIES = TLB_ENTRIES_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  dtlb_stage_if.slave        mem,
  input  logic               tlbwi,
  input  logic               tlbwr,
  input  logic               tlbp,
  input  logic [IDX_W-1:0]   tlb_index,
  input  logic [IDX_W-1:0]   wired,
  input  logic               wired_we,
  input  logic [31:0]        entryhi_in,
  input  logic [31:0]        entrylo0_in,
  input  logic [31:0]        entrylo1_in,
  output logic [31:0]        probe_index,
  output logic [31:0]        rd_entryhi,
  output logic [31:0]        rd_entrylo0,
  output logic [31:0]        rd_entrylo1,
  output logic [IDX_W-1:0]   random
`ifdef DTLB_PERF_EN
  ,
  output logic [31:0]        miss_count
`endif
);

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

  tlb_entry_t             entries [TLB_ENTRIES];
  tlb_entry_t             new_entry;
  tlb_entry_t             rd_entry;
  logic [TLB_ENTRIES-1:0] hit;
  logic [TLB_ENTRIES-1:0] probe_hit;
  tlb_page_t              hit_page [TLB_ENTRIES];
  tlb_page_t              sel_page;
  logic                   any_hit;
  logic                   probe_any;
  logic [IDX_W-1:0]       probe_idx;
  logic [IDX_W-1:0]       wr_idx;
  logic                   stalled;
  logic [2:0]             seg;
  logic                   mapped;

  assign stalled = stall[STALL_BIT];

  // Per-entry lookup comparators plus a probe comparator on EntryHi.
  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_entry
    dtlb_match u_match (
      .entry (entries[i]),
      .vpn2  (mem.vaddr[31:13]),
      .odd   (mem.vaddr[12]),
      .asid  (mem.cur_asid),
      .hit   (hit[i]),
      .page  (hit_page[i])
    );
    assign probe_hit[i] = (entries[i].vpn2 == entryhi_in[EH_VPN2_HI:EH_VPN2_LO]) &&
                          (entries[i].g ||
                           (entries[i].asid == entryhi_in[EH_ASID_HI:EH_ASID_LO]));
  end

  // Priority encode lookup hits; scanning downward leaves the lowest index.
  always_comb begin
    any_hit  = 1'b0;
    sel_page = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        sel_page = hit_page[i];
      end
    end
  end

  // Priority encode probe hits, lowest index wins.
  always_comb begin
    probe_any = 1'b0;
    probe_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (probe_hit[i]) begin
        probe_any = 1'b1;
        probe_idx = IDX_W'(i);
      end
    end
  end

  // Address translation and exception flags; refill > invalid > modify.
  always_comb begin
    seg           = mem.vaddr[31:29];
    mapped        = (seg != SEG_KSEG0) && (seg != SEG_KSEG1);
    mem.paddr     = mem.vaddr & KSEG_MASK;
    mem.uncached  = (seg == SEG_KSEG1);
    mem.d_refill  = 1'b0;
    mem.d_invalid = 1'b0;
    mem.d_modify  = 1'b0;
    if (mapped) begin
      mem.paddr    = any_hit ? {sel_page.pfn, mem.vaddr[11:0]} : 32'h0;
      mem.uncached = any_hit && (sel_page.c != C_CACHEABLE);
      if (mem.mem_en) begin
        if (!any_hit) begin
          mem.d_refill = 1'b1;
        end else if (!sel_page.v) begin
          mem.d_invalid = 1'b1;
        end else if (mem.mem_we && !sel_page.d) begin
          mem.d_modify = 1'b1;
        end
      end
    end
  end

  // Assemble the entry to be written; G is the AND of both halves' G bits.
  always_comb begin
    new_entry          = '0;
    new_entry.vpn2     = entryhi_in[EH_VPN2_HI:EH_VPN2_LO];
    new_entry.asid     = entryhi_in[EH_ASID_HI:EH_ASID_LO];
    new_entry.g        = entrylo0_in[EL_G] & entrylo1_in[EL_G];
    new_entry.lo0.pfn  = entrylo0_in[EL_PFN_HI:EL_PFN_LO];
    new_entry.lo0.c    = entrylo0_in[EL_C_HI:EL_C_LO];
    new_entry.lo0.d    = entrylo0_in[EL_D];
    new_entry.lo0.v    = entrylo0_in[EL_V];
    new_entry.lo1.pfn  = entrylo1_in[EL_PFN_HI:EL_PFN_LO];
    new_entry.lo1.c    = entrylo1_in[EL_C_HI:EL_C_LO];
    new_entry.lo1.d    = entrylo1_in[EL_D];
    new_entry.lo1.v    = entrylo1_in[EL_V];
  end

  // Indexed write takes precedence over random write.
  assign wr_idx = tlbwi ? tlb_index : random;

  // TLB array; writes proceed regardless of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (tlbwi || tlbwr) begin
      entries[wr_idx] <= new_entry;
    end
  end

  // TLBR read port.
  assign rd_entry    = entries[tlb_index];
  assign rd_entryhi  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
  assign rd_entrylo0 = pack_lo(rd_entry.lo0, rd_entry.g);
  assign rd_entrylo1 = pack_lo(rd_entry.lo1, rd_entry.g);

  // Probe result register; samples the array before any same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_index <= 32'h8000_0000;
    end else if (tlbp) begin
      probe_index <= probe_any ? 32'(probe_idx) : 32'h8000_0000;
    end
  end

  // Random counter: counts down to Wired then wraps to the top entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random <= RAND_TOP;
    end else if (wired_we) begin
      random <= RAND_TOP;
    end else if (!stalled) begin
      if (wired >= RAND_TOP || random == wired) begin
        random <= RAND_TOP;
      end else begin
        random <= random - 1'b1;
      end
    end
  end

`ifdef DTLB_PERF_EN
  // Saturating count of cycles presenting a refill miss downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count <= 32'h0;
    end else if (mem.mem_en && !stalled && mem.d_refill && miss_count != 32'hFFFF_FFFF) begin
      miss_count <= miss_count + 32'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, stall, entryhi_in[12:8],
                         entrylo0_in[31:26], entrylo1_in[31:26]};

endmodule

// File: tb/tb_dtlb_stage.sv
module tb_dtlb_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        tlbwi, tlbwr, tlbp;
  logic [3:0]  tlb_index, wired;
  logic        wired_we;
  logic [31:0] entryhi_in, entrylo0_in, entrylo1_in;
  logic [31:0] probe_index, rd_entryhi, rd_entrylo0, rd_entrylo1;
  logic [3:0]  random;
`ifdef DTLB_PERF_EN
  logic [31:0] miss_count;
`endif

  int vecs = 0;
  int errs = 0;

  dtlb_stage_if mem_bus ();

  dtlb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .mem         (mem_bus.slave),
    .tlbwi       (tlbwi),
    .tlbwr       (tlbwr),
    .tlbp        (tlbp),
    .tlb_index   (tlb_index),
    .wired       (wired),
    .wired_we    (wired_we),
    .entryhi_in  (entryhi_in),
    .entrylo0_in (entrylo0_in),
    .entrylo1_in (entrylo1_in),
    .probe_index (probe_index),
    .rd_entryhi  (rd_entryhi),
    .rd_entrylo0 (rd_entrylo0),
    .rd_entrylo1 (rd_entrylo1),
    .random      (random)
`ifdef DTLB_PERF_EN
    ,
    .miss_count  (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic en, input logic we, input logic [31:0] va, input logic [7:0] asid);
    mem_bus.mem_en   = en;
    mem_bus.mem_we   = we;
    mem_bus.vaddr    = va;
    mem_bus.cur_asid = asid;
    #1;
  endtask

  task automatic test_reset();
    access(1'b0, 1'b0, 32'h0040_0000, 8'd0);
    vecs++; if (random !== 4'd15) begin errs++; $display("FAIL reset_random: got %0d expected 15", random); end
    vecs++; if (probe_index !== 32'h8000_0000) begin errs++; $display("FAIL reset_probe: got %h expected 80000000", probe_index); end
    vecs++; if (mem_bus.d_refill !== 1'b0) begin errs++; $display("FAIL reset_noflag_when_idle: got %b expected 0", mem_bus.d_refill); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_kseg();
    access(1'b1, 1'b0, 32'h8000_1234, 8'd0);
    vecs++; if (mem_bus.paddr !== 32'h0000_1234) begin errs++; $display("FAIL kseg0_paddr: got %h expected 00001234", mem_bus.paddr); end
    vecs++; if (mem_bus.uncached !== 1'b0) begin errs++; $display("FAIL kseg0_uncached: got %b expected 0", mem_bus.uncached); end
    vecs++; if ({mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify} !== 3'b000) begin errs++; $display("FAIL kseg0_flags: got %b expected 000", {mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify}); end
    access(1'b1, 1'b1, 32'hA000_1234, 8'd0);
    vecs++; if (mem_bus.paddr !== 32'h0000_1234) begin errs++; $display("FAIL kseg1_paddr: got %h expected 00001234", mem_bus.paddr); end
    vecs++; if (mem_bus.uncached !== 1'b1) begin errs++; $display("FAIL kseg1_uncached: got %b expected 1", mem_bus.uncached); end
  endtask

  task automatic test_miss();
    access(1'b1, 1'b0, 32'h0040_0000, 8'd0);
    vecs++; if (mem_bus.d_refill !== 1'b1) begin errs++; $display("FAIL miss_refill: got %b expected 1", mem_bus.d_refill); end
    entryhi_in = 32'h0040_0000;
    tlbp = 1'b1;
    tick();
    tlbp = 1'b0;
    vecs++; if (probe_index !== 32'h8000_0000) begin errs++; $display("FAIL miss_probe: got %h expected 80000000", probe_index); end
  endtask

  task automatic test_hit();
    tlb_index   = 4'd3;
    entryhi_in  = 32'h0040_0005;
    entrylo0_in = 32'h0000_48DE;
    entrylo1_in = 32'h0000_0000;
    tlbwi = 1'b1;
    tick();
    tlbwi = 1'b0;
    access(1'b1, 1'b0, 32'h0040_0ABC, 8'd5);
    vecs++; if (mem_bus.paddr !== 32'h0012_3ABC) begin errs++; $display("FAIL hit_paddr: got %h expected 00123abc", mem_bus.paddr); end
    vecs++; if ({mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify, mem_bus.uncached} !== 4'b0000) begin errs++; $display("FAIL hit_flags: got %b expected 0000", {mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify, mem_bus.uncached}); end
    access(1'b1, 1'b0, 32'h0040_1000, 8'd5);
    vecs++; if ({mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify} !== 3'b010) begin errs++; $display("FAIL hit_odd_invalid: got %b expected 010", {mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify}); end
    vecs++; if (rd_entryhi !== 32'h0040_0005) begin errs++; $display("FAIL tlbr_hi: got %h expected 00400005", rd_entryhi); end
    vecs++; if (rd_entrylo0 !== 32'h0000_48DE) begin errs++; $display("FAIL tlbr_lo0: got %h expected 000048de", rd_entrylo0); end
    entryhi_in = 32'h0040_0005;
    tlbp = 1'b1;
    tick();
    tlbp = 1'b0;
    vecs++; if (probe_index !== 32'h0000_0003) begin errs++; $display("FAIL probe_hit: got %h expected 00000003", probe_index); end
  endtask

  task automatic test_modify();
    tlb_index   = 4'd3;
    entryhi_in  = 32'h0040_0005;
    entrylo0_in = 32'h0000_48DA;
    entrylo1_in = 32'h0000_0000;
    tlbwi = 1'b1;
    tick();
    tlbwi = 1'b0;
    access(1'b1, 1'b1, 32'h0040_0000, 8'd5);
    vecs++; if ({mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify} !== 3'b001) begin errs++; $display("FAIL store_modify: got %b expected 001", {mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify}); end
    access(1'b1, 1'b0, 32'h0040_0000, 8'd5);
    vecs++; if ({mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify} !== 3'b000) begin errs++; $display("FAIL load_no_modify: got %b expected 000", {mem_bus.d_refill, mem_bus.d_invalid, mem_bus.d_modify}); end
    access(1'b1, 1'b0, 32'h0040_0000, 8'd6);
    vecs++; if (mem_bus.d_refill !== 1'b1) begin errs++; $display("FAIL asid_mismatch_refill: got %b expected 1", mem_bus.d_refill); end
    // make entry 3 global; a different ASID must now hit
    entrylo0_in = 32'h0000_48DB;
    entrylo1_in = 32'h0000_0001;
    tlbwi = 1'b1;
    tick();
    tlbwi = 1'b0;
    access(1'b1, 1'b0, 32'h0040_0000, 8'd6);
    vecs++; if (mem_bus.paddr !== 32'h0012_3000 || mem_bus.d_refill !== 1'b0) begin errs++; $display("FAIL global_hit: got paddr %h refill %b expected 00123000 0", mem_bus.paddr, mem_bus.d_refill); end
    // overlapping entry at index 1 must take precedence
    tlb_index   = 4'd1;
    entryhi_in  = 32'h0040_0006;
    entrylo0_in = 32'h0001_159E;
    entrylo1_in = 32'h0000_0000;
    tlbwi = 1'b1;
    tick();
    tlbwi = 1'b0;
    access(1'b1, 1'b0, 32'h0040_0000, 8'd6);
    vecs++; if (mem_bus.paddr !== 32'h0045_6000) begin errs++; $display("FAIL lowest_index_wins: got %h expected 00456000", mem_bus.paddr); end
  endtask

  task automatic test_random();
    logic [3:0] exp;
    stall    = 6'b0;
    wired    = 4'd4;
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    vecs++; if (random !== 4'd15) begin errs++; $display("FAIL random_after_wired_we: got %0d expected 15", random); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = (k <= 11) ? 4'(15 - k) : 4'(27 - k);
      vecs++; if (random !== exp) begin errs++; $display("FAIL random_seq_%0d: got %0d expected %0d", k, random, exp); end
    end
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    vecs++; if (random !== 4'd15) begin errs++; $display("FAIL random_wired_we_mid: got %0d expected 15", random); end
  endtask

  task automatic test_stall_tlbwr();
    stall = 6'b01_0000;
    tick();
    tick();
    vecs++; if (random !== 4'd15) begin errs++; $display("FAIL random_stall_hold: got %0d expected 15", random); end
    entryhi_in  = 32'h0080_0005;
    entrylo0_in = 32'h0000_1DDE;
    entrylo1_in = 32'h0000_0000;
    tlbwr = 1'b1;
    tick();
    tlbwr = 1'b0;
    tlb_index = 4'd15;
    access(1'b1, 1'b0, 32'h0080_0000, 8'd5);
    vecs++; if (rd_entryhi !== 32'h0080_0005) begin errs++; $display("FAIL tlbwr_entry: got %h expected 00800005", rd_entryhi); end
    vecs++; if (mem_bus.paddr !== 32'h0007_7000) begin errs++; $display("FAIL tlbwr_lookup: got %h expected 00077000", mem_bus.paddr); end
    // simultaneous writes: the indexed write goes to entry 2 only
    tlb_index  = 4'd2;
    entryhi_in = 32'h00C0_0005;
    tlbwi = 1'b1;
    tlbwr = 1'b1;
    tick();
    tlbwi = 1'b0;
    tlbwr = 1'b0;
    #1;
    vecs++; if (rd_entryhi !== 32'h00C0_0005) begin errs++; $display("FAIL wi_wr_index: got %h expected 00c00005", rd_entryhi); end
    tlb_index = 4'd15;
    #1;
    vecs++; if (rd_entryhi !== 32'h0080_0005) begin errs++; $display("FAIL wi_wr_random_untouched: got %h expected 00800005", rd_entryhi); end
    stall = 6'b0;
  endtask

  task automatic test_wired_high();
    wired    = 4'd15;
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++; if (random !== 4'd15) begin errs++; $display("FAIL random_wired_max_%0d: got %0d expected 15", k, random); end
    end
    wired    = 4'd0;
  endtask

  task automatic test_async_reset();
    wired = 4'd0;
    tick();
    tick();
    access(1'b1, 1'b0, 32'h0040_0000, 8'd5);
    #2;
    rst = 1'b1;
    #1;
    vecs++; if (random !== 4'd15) begin errs++; $display("FAIL async_rst_random: got %0d expected 15", random); end
    vecs++; if (mem_bus.d_refill !== 1'b1) begin errs++; $display("FAIL async_rst_refill: got %b expected 1", mem_bus.d_refill); end
    tlb_index = 4'd3;
    #1;
    vecs++; if (rd_entryhi !== 32'h0) begin errs++; $display("FAIL async_rst_entry_clear: got %h expected 00000000", rd_entryhi); end
    vecs++; if (probe_index !== 32'h8000_0000) begin errs++; $display("FAIL async_rst_probe: got %h expected 80000000", probe_index); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'b0;
    tlbwi = 1'b0; tlbwr = 1'b0; tlbp = 1'b0;
    tlb_index = 4'd0; wired = 4'd0; wired_we = 1'b0;
    entryhi_in = 32'h0; entrylo0_in = 32'h0; entrylo1_in = 32'h0;
    mem_bus.mem_en = 1'b0; mem_bus.mem_we = 1'b0;
    mem_bus.vaddr = 32'h0; mem_bus.cur_asid = 8'h0;
    tick();
    tick();
    test_reset();
    test_kseg();
    test_miss();
    test_hit();
    test_modify();
    test_random();
    test_stall_tlbwr();
    test_wired_high();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
